// File: rtl/branch_pred_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// branch_pred_ctrl_pkg : PC-mux select encoding, PHT counter type and helpers
// Revision 1.0
// ============================================================================
package branch_pred_ctrl_pkg;

  typedef enum logic [2:0] {
    PCMUX_PLUS2   = 3'b000,
    PCMUX_BRTGT   = 3'b001,
    PCMUX_JUMP    = 3'b010,
    PCMUX_TRAP    = 3'b011,
    PCMUX_PRED    = 3'b100,
    PCMUX_RECOVER = 3'b101
  } lc3b_pcmux_sel;

  typedef logic [1:0] lc3b_bpctr;

  localparam lc3b_bpctr BPCTR_SNT = 2'b00;
  localparam lc3b_bpctr BPCTR_WNT = 2'b01;
  localparam lc3b_bpctr BPCTR_WT  = 2'b10;
  localparam lc3b_bpctr BPCTR_ST  = 2'b11;

  localparam logic [3:0] OP_BR = 4'b0000;

  function automatic lc3b_bpctr bpctr_next(input lc3b_bpctr c, input logic taken);
    lc3b_bpctr n;
    n = c;
    if (taken && c != BPCTR_ST)
      n = c + 2'b01;
    else if (!taken && c != BPCTR_SNT)
      n = c - 2'b01;
    return n;
  endfunction

endpackage
`default_nettype wire

// File: rtl/branch_pred_ctrl_if.sv
`default_nettype none
// ============================================================================
// branch_pred_ctrl_if : fetch / resolve / redirect bundle of the predictor
// Revision 1.0
// ============================================================================
interface branch_pred_ctrl_if #(
  parameter int IDX_BITS = 6,
  parameter int CNT_W    = 16
);
  logic [15:0]         fetch_pc;
  logic [3:0]          fetch_opcode;
  logic [2:0]          fetch_nzp;
  logic                predict_taken;
  logic [IDX_BITS-1:0] predict_idx;
  logic                exme_trap;
  logic                idex_jump;
  logic                res_valid;
  logic [IDX_BITS-1:0] res_idx;
  logic                res_pred;
  logic                res_taken;
  logic [2:0]          res_nzp;
  logic [2:0]          pcmux_sel;
  logic                flush;
  logic [CNT_W-1:0]    mispredict_count;

  modport slave (
    input  fetch_pc, fetch_opcode, fetch_nzp, exme_trap, idex_jump,
           res_valid, res_idx, res_pred, res_taken, res_nzp,
    output predict_taken, predict_idx, pcmux_sel, flush, mispredict_count
  );

  modport master (
    output fetch_pc, fetch_opcode, fetch_nzp, exme_trap, idex_jump,
           res_valid, res_idx, res_pred, res_taken, res_nzp,
    input  predict_taken, predict_idx, pcmux_sel, flush, mispredict_count
  );
endinterface
`default_nettype wire

// File: rtl/branch_pred_ctrl_bp_pht.sv
`default_nettype none
// ============================================================================
// bp_pht : 2-bit saturating counter table, async read, trained on resolve
// Revision 1.0
// ============================================================================
module bp_pht
  import branch_pred_ctrl_pkg::*;
#(
  parameter int        IDX_BITS = 6,
  parameter lc3b_bpctr INIT_CTR = BPCTR_WNT
) (
  input  wire logic                clk,
  input  wire logic                reset,
  input  wire logic [IDX_BITS-1:0] i_rd_idx,
  output lc3b_bpctr                o_rd_ctr,
  input  wire logic                i_wr_en,
  input  wire logic [IDX_BITS-1:0] i_wr_idx,
  input  wire logic                i_wr_taken
);
  localparam int DEPTH = 1 << IDX_BITS;

  lc3b_bpctr r_ctr [DEPTH];

  // Read returns the pre-update value when it collides with a same-cycle write.
  assign o_rd_ctr = r_ctr[i_rd_idx];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++)
        r_ctr[i] <= INIT_CTR;
    end else if (i_wr_en) begin
      r_ctr[i_wr_idx] <= bpctr_next(r_ctr[i_wr_idx], i_wr_taken);
    end
  end
endmodule
`default_nettype wire

// File: rtl/branch_pred_ctrl.sv
`default_nettype none
// ============================================================================
// branch_pred_ctrl : PHT branch predictor, PC-mux priority, flush, stats.
// Optional gshare indexing via macro BP_GSHARE_EN.   Revision 1.0
// ============================================================================
module branch_pred_ctrl
  import branch_pred_ctrl_pkg::*;
#(
  parameter int        IDX_BITS = 6,
  parameter int        CNT_W    = 16,
  parameter lc3b_bpctr INIT_CTR = BPCTR_WNT
) (
  input  wire logic          clk,
  input  wire logic          reset,
  branch_pred_ctrl_if.slave  bus
);
  logic [IDX_BITS-1:0] w_idx;
  lc3b_bpctr           w_ctr;
  logic                w_resolve;
  logic                w_mis_t;
  logic                w_mis_nt;
  logic                w_pred;
  lc3b_pcmux_sel       w_sel;
  logic [CNT_W-1:0]    r_cnt;

  wire w_unused = ^{bus.fetch_pc[15:IDX_BITS+1], bus.fetch_pc[0]};

  assign w_resolve = bus.res_valid && (bus.res_nzp != 3'b000);

`ifdef BP_GSHARE_EN
  logic [IDX_BITS-1:0] r_ghr;

  // History is only shifted by resolved branches, so it is never speculative.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      r_ghr <= '0;
    else if (w_resolve)
      r_ghr <= {r_ghr[IDX_BITS-2:0], bus.res_taken};
  end

  assign w_idx = bus.fetch_pc[IDX_BITS:1] ^ r_ghr;
`else
  assign w_idx = bus.fetch_pc[IDX_BITS:1];
`endif

  bp_pht #(
    .IDX_BITS (IDX_BITS),
    .INIT_CTR (INIT_CTR)
  ) u_pht (
    .clk        (clk),
    .reset      (reset),
    .i_rd_idx   (w_idx),
    .o_rd_ctr   (w_ctr),
    .i_wr_en    (w_resolve),
    .i_wr_idx   (bus.res_idx),
    .i_wr_taken (bus.res_taken)
  );

  assign w_mis_t  = w_resolve &&  bus.res_taken && !bus.res_pred;
  assign w_mis_nt = w_resolve && !bus.res_taken &&  bus.res_pred;

  // nzp == 111 is an unconditional branch, so it is always predicted taken.
  assign w_pred = (bus.fetch_nzp == 3'b111) ||
                  ((bus.fetch_opcode == OP_BR) && (bus.fetch_nzp != 3'b000) && w_ctr[1]);

  always_comb begin
    w_sel = PCMUX_PLUS2;
    if (bus.exme_trap)
      w_sel = PCMUX_TRAP;
    else if (bus.idex_jump)
      w_sel = PCMUX_JUMP;
    else if (w_mis_t)
      w_sel = PCMUX_BRTGT;
    else if (w_mis_nt)
      w_sel = PCMUX_RECOVER;
    else if (w_pred)
      w_sel = PCMUX_PRED;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      r_cnt <= '0;
    else if ((w_mis_t || w_mis_nt) && (r_cnt != {CNT_W{1'b1}}))
      r_cnt <= r_cnt + 1'b1;
  end

  assign bus.predict_taken    = w_pred;
  assign bus.predict_idx      = w_idx;
  assign bus.pcmux_sel        = w_sel;
  assign bus.flush            = w_mis_t || w_mis_nt;
  assign bus.mispredict_count = r_cnt;
endmodule
`default_nettype wire

// File: doc/branch_pred_ctrl.md
Name: branch_pred_ctrl

Overview:
- Parametrised successor to the fetch-redirect controller.
- Adds a pattern history table (PHT) of 2-bit saturating counters, indexed by fetch PC, that produces BR predictions at fetch. Counters are trained at resolve in EX.
- Generates the PC-mux select with trap/jump/mispredict priority and a flush pulse on mispredict.
- Keeps a saturating mispredict counter for performance debug.

Parameters:
IDX_BITS, 6, PHT index width; PHT has 2**IDX_BITS entries; legal range 2..8
CNT_W, 16, width of mispredict statistics counter
INIT_CTR, 2'b01, PHT counter reset value (weakly not-taken)

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-high reset
fetch_pc  in  16  PC of instruction in fetch
fetch_opcode  in  4  opcode of fetched instruction (lc3b_opcode)
fetch_nzp  in  3  IR[11:9] of fetched instruction
predict_taken  out  1  prediction for the fetched instruction
predict_idx  out  IDX_BITS  PHT index used; pipelined alongside the instruction
exme_trap  in  1  TRAP in EX/MEM stage
idex_jump  in  1  JSR/JSRR/JMP/RET in ID/EX stage
res_valid  in  1  ID/EX holds a valid BR resolving this cycle (qualified by stall)
res_idx  in  IDX_BITS  predict_idx carried with the resolving BR
res_pred  in  1  prediction made for it at fetch
res_taken  in  1  br_en from EX
res_nzp  in  3  nzp field of resolving BR
pcmux_sel  out  3  PC-mux select (lc3b_pcmux_sel)
flush  out  1  squash younger instructions (mispredict)
mispredict_count  out  CNT_W  saturating mispredict count

Behaviour:
- Index computation: idx = fetch_pc[IDX_BITS:1] (PC bit 0 always 0). predict_idx = idx, driven combinationally.
- Prediction: predict_taken is combinational.
  - 1 iff fetch_opcode == op_br and fetch_nzp != 000 and PHT[idx][1] == 1.
  - Always 1 if fetch_nzp == 111.
- Resolve: a BR resolves when res_valid = 1 and res_nzp != 000. Resolve with nzp == 000 is a NOP: no training, no mispredict.
- Training: on the rising edge of a resolve, PHT[res_idx] saturates up if res_taken (max 11) and down otherwise (min 00).
- Same-cycle read/write to one entry: fetch sees the pre-update value (no bypass).
- mis_t = resolve & res_taken & !res_pred.
- mis_nt = resolve & !res_taken & res_pred.
- pcmux_sel priority, first match wins:
  - exme_trap -> 011
  - idex_jump -> 010
  - mis_t -> 001 (branch target)
  - mis_nt -> 101 (recover to fall-through PC+2 of BR)
  - predict_taken -> 100 (predicted target)
  - otherwise -> 000 (PC+2)
- flush = mis_t | mis_nt, combinational. It is asserted even when trap or jump wins the select.
- mispredict_count:
  - Increments by 1 on each clock with mis_t | mis_nt.
  - Saturates at all ones; never wraps.
- Reset:
  - Every PHT entry -> INIT_CTR; mispredict_count -> 0; GHR -> 0 (if enabled).
  - Combinational outputs during reset: pcmux_sel follows its inputs with PHT = INIT_CTR; predict_taken = 0 unless nzp == 111.
- Reset mid-operation clears training immediately (asynchronous). No partial update is retained.

Optional Feature:
- Macro BP_GSHARE_EN.
- Defined:
  - A global history register ghr[IDX_BITS-1:0] is added.
  - idx = fetch_pc[IDX_BITS:1] ^ ghr.
  - On each resolve edge, ghr <= {ghr[IDX_BITS-2:0], res_taken}. Update is non-speculative.
  - Training still uses res_idx, the index captured at fetch.
- Undefined: no ghr; pure PC-indexed bimodal; port list identical.

Decomposition:
- lc3b_types additions:
  - typedef lc3b_pcmux_sel (3-bit enum: PCMUX_PLUS2, PCMUX_BRTGT, PCMUX_JUMP, PCMUX_TRAP, PCMUX_PRED, PCMUX_RECOVER).
  - typedef lc3b_bpctr (2-bit).
  - Constants BPCTR_SNT/WNT/WT/ST.
- Sub-module bp_pht: counter array with read port, saturating write port, and async reset. The top holds indexing, ghr, priority mux and stats.

Test Plan:
1. Reset, then fetch BR nzp=010 at pc=x3000 -> predict_taken=0, pcmux_sel=000, predict_idx=0.
2. Two resolves taken at idx 0 (res_pred=0 the first time) -> first cycle: pcmux_sel=001, flush=1, mispredict_count=1. Then fetch x3000 -> predict_taken=1, pcmux_sel=100.
3. Train idx 5 to 11, then three not-taken resolves -> counter 10, 01, 00. After the second, predict_taken=0. A fourth not-taken stays at 00.
4. Resolve mis_nt (pred=1, taken=0, nzp=001) while exme_trap=1 -> pcmux_sel=011, flush=1.
5. Resolve with nzp=000, res_pred=0, taken=1 -> no PHT change, flush=0, count unchanged. Fetch BR nzp=111 -> predict_taken=1.
6. Force 2**CNT_W mispredicts (CNT_W=4) -> mispredict_count holds 15. Assert reset mid-run -> all counters 01, count 0. Under BP_GSHARE_EN: ghr=0, and taken,taken -> ghr=..011, changing the idx for the same PC.
